ps2_scan_ctrl: RTL and testbench

PS2_SCAN_CTRL -- requirements
Module: ps2_scan_ctrl

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_evt_fifo.sv | 55 +++++
 rtl/ps2_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_ps2_scan_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_pkg : shared PS/2 decoder types and scancode constants         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // "release" is a reserved word, so the break flag is called rls
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rls;
  } ps2_evt_t;

  // Keyboard status/ack bytes that never start an event
  function automatic logic is_filler(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_evt_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_evt_fifo : synchronous show-ahead FIFO for decoded key events  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == DEPTH_CNT);
  assign data_o    = mem_q[rd_ptr_q];
  assign w_do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a write when the head leaves on the same edge
  assign w_do_push = push_i && (!full_o || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (w_do_push && !w_do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (!w_do_push && w_do_pop) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/ps2_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_scan_ctrl : PS/2 set-2 scancode decoder with event FIFO        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ps2_scan_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic [7:0] press_cnt
);

  ps2_state_e state_q, state_d;
  logic       held_q;
  logic [7:0] held_code_q;
  logic       held_ext_q;
  logic       ovf_q;
  logic [7:0] press_cnt_q;

  ps2_evt_t   w_evt;
  ps2_evt_t   w_head;
  logic       w_evt_done;
  logic       w_suppress;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_held_match;

  always_comb begin
    state_d    = state_q;
    w_evt_done = 1'b0;
    w_evt.code = rx_data;
    w_evt.ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    w_evt.rls  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == PS2_EXT)      state_d = ST_EXT;
          else if (rx_data == PS2_BRK) state_d = ST_BRK;
          else                         w_evt_done = !is_filler(rx_data);
        end
        ST_EXT: begin
          if (rx_data == PS2_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d    = ST_IDLE;
            w_evt_done = (rx_data != PS2_EXT);
          end
        end
        default: begin
          // A second prefix here is a protocol error: resync in IDLE
          state_d    = ST_IDLE;
          w_evt_done = (rx_data != PS2_EXT) && (rx_data != PS2_BRK);
        end
      endcase
    end
  end

  assign w_held_match = held_q && (w_evt.code == held_code_q) && (w_evt.ext == held_ext_q);
  // Typematic repeats of the key already down are not reported again
  assign w_suppress   = !w_evt.rls && w_held_match;
  assign w_push       = w_evt_done && !w_suppress;
  assign w_pop        = !w_empty && ev_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      held_q      <= 1'b0;
      held_code_q <= '0;
      held_ext_q  <= 1'b0;
      ovf_q       <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_evt_done) begin
        if (!w_evt.rls) begin
          held_q      <= 1'b1;
          held_code_q <= w_evt.code;
          held_ext_q  <= w_evt.ext;
        end else if (w_held_match) begin
          held_q <= 1'b0;
        end
      end
      if (w_push && w_full && !w_pop) ovf_q <= 1'b1;
      else if (ovf_clr)               ovf_q <= 1'b0;
      if (w_push && !w_evt.rls && (!w_full || w_pop))
        press_cnt_q <= press_cnt_q + 8'd1;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_evt_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .data_i  (w_evt),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Storage is not reset, so the head is masked to zero while empty
  assign ev_valid   = !w_empty;
  assign ev_code    = ev_valid ? w_head.code : 8'h00;
  assign ev_ext     = ev_valid && w_head.ext;
  assign ev_release = ev_valid && w_head.rls;
  assign ovf        = ovf_q;
  assign press_cnt  = press_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ps2_scan_ctrl : directed vector bench for ps2_scan_ctrl         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ps2_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_release;
  logic       ev_valid;
  logic       ev_ready;
  logic       ovf;
  logic       ovf_clr;
  logic [7:0] press_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ps2_scan_ctrl #(.FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_release (ev_release),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .press_cnt  (press_cnt)
  );

  typedef struct {
    logic       rstn;
    logic       rv;
    logic [7:0] d;
    logic       rdy;
    logic       ev;
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       ov;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [32];

  task automatic step(input logic rstn_v, input logic rv, input logic [7:0] d,
                      input logic rdy, input logic clr);
    rst_n    = rstn_v;
    rx_valid = rv;
    rx_data  = d;
    ev_ready = rdy;
    ovf_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input logic [7:0] code,
                       input logic ext, input logic rel, input logic ov, input logic [7:0] cnt);
    n_vec++;
    if (ev_valid !== ev || ev_code !== code || ev_ext !== ext ||
        ev_release !== rel || ovf !== ov || press_cnt !== cnt) begin
      n_err++;
      $display("FAIL %s: got v=%b code=%h ext=%b rel=%b ovf=%b cnt=%0d, want v=%b code=%h ext=%b rel=%b ovf=%b cnt=%0d",
               name, ev_valid, ev_code, ev_ext, ev_release, ovf, press_cnt,
               ev, code, ext, rel, ov, cnt);
    end
  endtask

  initial begin
    //          rstn rv  data  rdy  ev  code  ext rel ovf cnt
    tbl[0]  = '{1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd0};
    tbl[1]  = '{1'b1,1'b1,8'h1C,1'b1,1'b1,8'h1C,1'b0,1'b0,1'b0,8'd1};
    tbl[2]  = '{1'b1,1'b1,8'hF0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd1};
    tbl[3]  = '{1'b1,1'b1,8'h1C,1'b1,1'b1,8'h1C,1'b0,1'b1,1'b0,8'd1};
    tbl[4]  = '{1'b1,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd1};
    tbl[5]  = '{1'b1,1'b1,8'hE0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd1};
    tbl[6]  = '{1'b1,1'b1,8'h75,1'b1,1'b1,8'h75,1'b1,1'b0,1'b0,8'd2};
    tbl[7]  = '{1'b1,1'b1,8'hE0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd2};
    tbl[8]  = '{1'b1,1'b1,8'hF0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd2};
    tbl[9]  = '{1'b1,1'b1,8'h75,1'b1,1'b1,8'h75,1'b1,1'b1,1'b0,8'd2};
    tbl[10] = '{1'b1,1'b1,8'h1C,1'b1,1'b1,8'h1C,1'b0,1'b0,1'b0,8'd3};
    tbl[11] = '{1'b1,1'b1,8'h1C,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd3};
    tbl[12] = '{1'b1,1'b1,8'h1C,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd3};
    tbl[13] = '{1'b0,1'b1,8'h1C,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd0};
    tbl[14] = '{1'b1,1'b1,8'h1C,1'b1,1'b1,8'h1C,1'b0,1'b0,1'b0,8'd1};
    tbl[15] = '{1'b1,1'b1,8'h1C,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd1};
    tbl[16] = '{1'b1,1'b1,8'h1C,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd1};
    tbl[17] = '{1'b1,1'b1,8'hE0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd1};
    tbl[18] = '{1'b1,1'b1,8'hF0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd1};
    tbl[19] = '{1'b0,1'b1,8'h1C,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd0};
    tbl[20] = '{1'b1,1'b1,8'h1C,1'b1,1'b1,8'h1C,1'b0,1'b0,1'b0,8'd1};
    tbl[21] = '{1'b1,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd1};
    tbl[22] = '{1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd0};
    tbl[23] = '{1'b1,1'b1,8'hAA,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd0};
    tbl[24] = '{1'b1,1'b1,8'hE0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd0};
    tbl[25] = '{1'b1,1'b1,8'hE0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd0};
    tbl[26] = '{1'b1,1'b1,8'h1C,1'b1,1'b1,8'h1C,1'b0,1'b0,1'b0,8'd1};
    tbl[27] = '{1'b1,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd1};
    tbl[28] = '{1'b1,1'b1,8'hF0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,8'd1};
    tbl[29] = '{1'b1,1'b1,8'h1C,1'b0,1'b1,8'h1C,1'b0,1'b1,1'b0,8'd1};
    tbl[30] = '{1'b1,1'b0,8'h00,1'b0,1'b1,8'h1C,1'b0,1'b1,1'b0,8'd1};
    tbl[31] = '{1'b1,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd1};

    for (int i = 0; i < 32; i++) begin
      step(tbl[i].rstn, tbl[i].rv, tbl[i].d, tbl[i].rdy, 1'b0);
      check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].code, tbl[i].ext,
            tbl[i].rel, tbl[i].ov, tbl[i].cnt);
    end

    // Overflow: 9 distinct presses into a depth-8 FIFO with no consumer
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    check("fill8", 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'd8);
    step(1'b1, 1'b1, 8'h18, 1'b0, 1'b0);
    check("drop9", 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 8'd8);
    step(1'b1, 1'b1, 8'h19, 1'b0, 1'b1);
    check("set_beats_clr", 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 8'd8);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'd8);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      if (i < 7) check($sformatf("drain%0d", i), 1'b1, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b0, 8'd8);
      else       check("drain_empty", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd8);
    end

    // Full FIFO with simultaneous push and pop: nothing lost
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    check("full_again", 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'd8);
    step(1'b1, 1'b1, 8'h28, 1'b1, 1'b0);
    check("push_pop_full", 1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 8'd9);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      if (i < 7) check($sformatf("order%0d", i), 1'b1, 8'h22 + 8'(i), 1'b0, 1'b0, 1'b0, 8'd9);
      else       check("order_empty", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd9);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
